cache_mem_arbiter: RTL

Sequencing controller that shares the single-ported unified main memory between the I-cache and D-cache miss handlers. It grants one requester at a time with round-robin on ties, and drives the memory's read/write strobes for exactly MEM_LAT cycles per access. It runs a D-cache dirty-line write-back before the D fill, and returns the fetched line with a one-cycle done pulse. It sits between both cache controllers and the memory model.

---
 rtl/cache_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares a single-ported main memory between I-cache and D-cache miss handlers.
// Round-robin on ties; D-side dirty victims are written back before the D fill.
module cache_mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 13,
    parameter int LINE_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wb_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        DFILL = 3'd2,
        IFILL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                last_d_q, last_d_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]   dfill_addr_q, dfill_addr_d;
    logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_d_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dfill_addr_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_d_q     <= last_d_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            dfill_addr_q <= dfill_addr_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d_d     = last_d_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        dfill_addr_d = dfill_addr_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                // D wins when alone, or on a tie when I was served last
                if (d_req && (!i_req || !last_d_q)) begin
                    last_d_d     = 1'b1;
                    cnt_d        = '0;
                    dfill_addr_d = d_addr;
                    if (d_wb) begin
                        state_d     = WB;
                        mem_addr_d  = d_wb_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d    = DFILL;
                        mem_addr_d = d_addr;
                    end
                end else if (i_req) begin
                    last_d_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = IFILL;
                    mem_addr_d = i_addr;
                end
            end
            WB: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    mem_addr_d = dfill_addr_q;
                    state_d    = DFILL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DFILL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    d_rdata_d = mem_rdata;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IFILL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    i_rdata_d = mem_rdata;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so reset drops strobes at once
    assign mem_re    = (state_q == DFILL) || (state_q == IFILL);
    assign mem_we    = (state_q == WB);
    assign busy      = (state_q != IDLE);
    assign i_done    = (state_q == DONE) && !last_d_q;
    assign d_done    = (state_q == DONE) && last_d_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
